// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter.
package axi_read_arbiter_pkg;

  // AXI AR/R side-band field widths
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_LOCK_W  = 2;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_RESP_W  = 2;

  // Master indices; the index travels in bit 0 of the slave-side ID
  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  // AXI burst types
  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

  // AXI beat sizes (bytes per beat = 2**size)
  localparam logic [AXI_SIZE_W-1:0] SIZE_1B  = 3'd0;
  localparam logic [AXI_SIZE_W-1:0] SIZE_2B  = 3'd1;
  localparam logic [AXI_SIZE_W-1:0] SIZE_4B  = 3'd2;
  localparam logic [AXI_SIZE_W-1:0] SIZE_8B  = 3'd3;

  // Burst FSM: accept a request, present it to the slave, stream the data back
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // One-hot grant vector for a master index
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer starts out favouring master 1.
module rr_arbiter2
  import axi_read_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // High when master 1 wins a tie
  logic prio_m1;

  // Grant selection: a lone requester always wins, ties go to the pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = idx_to_onehot(M_INST);
      2'b10:   grant = idx_to_onehot(M_DATA);
      2'b11:   grant = idx_to_onehot(prio_m1);
      default: grant = 2'b00;
    endcase
  end

  // Pointer update: after a taken grant, the other master gets priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio_m1 <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      prio_m1 <= grant[0];
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Merges an instruction-side and a data-side AXI read port onto one slave
// port, with a single outstanding burst and the master index in RID bit 0.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,

  // Instruction-side master
  input  logic [ID_W-1:0]        m0_arid,
  input  logic [ADDR_W-1:0]      m0_araddr,
  input  logic [AXI_LEN_W-1:0]   m0_arlen,
  input  logic [AXI_SIZE_W-1:0]  m0_arsize,
  input  logic [AXI_BURST_W-1:0] m0_arburst,
  input  logic [AXI_LOCK_W-1:0]  m0_arlock,
  input  logic [AXI_CACHE_W-1:0] m0_arcache,
  input  logic [AXI_PROT_W-1:0]  m0_arprot,
  input  logic                   m0_arvalid,
  output logic                   m0_arready,
  output logic [ID_W-1:0]        m0_rid,
  output logic [DATA_W-1:0]      m0_rdata,
  output logic [AXI_RESP_W-1:0]  m0_rresp,
  output logic                   m0_rlast,
  output logic                   m0_rvalid,
  input  logic                   m0_rready,

  // Data-side master
  input  logic [ID_W-1:0]        m1_arid,
  input  logic [ADDR_W-1:0]      m1_araddr,
  input  logic [AXI_LEN_W-1:0]   m1_arlen,
  input  logic [AXI_SIZE_W-1:0]  m1_arsize,
  input  logic [AXI_BURST_W-1:0] m1_arburst,
  input  logic [AXI_LOCK_W-1:0]  m1_arlock,
  input  logic [AXI_CACHE_W-1:0] m1_arcache,
  input  logic [AXI_PROT_W-1:0]  m1_arprot,
  input  logic                   m1_arvalid,
  output logic                   m1_arready,
  output logic [ID_W-1:0]        m1_rid,
  output logic [DATA_W-1:0]      m1_rdata,
  output logic [AXI_RESP_W-1:0]  m1_rresp,
  output logic                   m1_rlast,
  output logic                   m1_rvalid,
  input  logic                   m1_rready,

  // Merged slave port
  output logic [ID_W-1:0]        s_arid,
  output logic [ADDR_W-1:0]      s_araddr,
  output logic [AXI_LEN_W-1:0]   s_arlen,
  output logic [AXI_SIZE_W-1:0]  s_arsize,
  output logic [AXI_BURST_W-1:0] s_arburst,
  output logic [AXI_LOCK_W-1:0]  s_arlock,
  output logic [AXI_CACHE_W-1:0] s_arcache,
  output logic [AXI_PROT_W-1:0]  s_arprot,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic [ID_W-1:0]        s_rid,
  input  logic [DATA_W-1:0]      s_rdata,
  input  logic [AXI_RESP_W-1:0]  s_rresp,
  input  logic                   s_rlast,
  input  logic                   s_rvalid,
  output logic                   s_rready,

  output logic                   rid_err
);

  arb_state_e state;
  logic       gnt_idx;
  logic [1:0] req;
  logic [1:0] grant;
  logic       take;
  logic       data_phase;
  logic       m0_sel;
  logic       m1_sel;

  logic [ID_W-1:0]        sel_id;
  logic [ADDR_W-1:0]      sel_addr;
  logic [AXI_LEN_W-1:0]   sel_len;
  logic [AXI_SIZE_W-1:0]  sel_size;
  logic [AXI_BURST_W-1:0] sel_burst;
  logic [AXI_LOCK_W-1:0]  sel_lock;
  logic [AXI_CACHE_W-1:0] sel_cache;
  logic [AXI_PROT_W-1:0]  sel_prot;
  logic [ID_W-1:0]        ret_id;

  // The top ID bit of each master is displaced by the master index
  logic unused_id_msb;
  assign unused_id_msb = &{1'b0, m0_arid[ID_W-1], m1_arid[ID_W-1]};

  // Round-robin choice between the two AR requesters
  rr_arbiter2 u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .advance (take),
    .grant   (grant)
  );

  // AR acceptance only happens in IDLE, and only for the chosen master
  assign req        = {m1_arvalid, m0_arvalid};
  assign take       = resetn && (state == ST_IDLE) && (req != 2'b00);
  assign m0_arready = take & grant[0];
  assign m1_arready = take & grant[1];

  // AR field mux for the master being granted this cycle
  assign sel_id    = grant[1] ? m1_arid    : m0_arid;
  assign sel_addr  = grant[1] ? m1_araddr  : m0_araddr;
  assign sel_len   = grant[1] ? m1_arlen   : m0_arlen;
  assign sel_size  = grant[1] ? m1_arsize  : m0_arsize;
  assign sel_burst = grant[1] ? m1_arburst : m0_arburst;
  assign sel_lock  = grant[1] ? m1_arlock  : m0_arlock;
  assign sel_cache = grant[1] ? m1_arcache : m0_arcache;
  assign sel_prot  = grant[1] ? m1_arprot  : m0_arprot;

  // R routing: only the granted master sees the burst, the other stays quiet
  assign data_phase = resetn && (state == ST_DATA);
  assign m0_sel     = data_phase && (gnt_idx == M_INST);
  assign m1_sel     = data_phase && (gnt_idx == M_DATA);
  assign ret_id     = {1'b0, s_rid[ID_W-1:1]};

  assign m0_rvalid = m0_sel & s_rvalid;
  assign m0_rdata  = m0_sel ? s_rdata : '0;
  assign m0_rresp  = m0_sel ? s_rresp : '0;
  assign m0_rlast  = m0_sel & s_rlast;
  assign m0_rid    = m0_sel ? ret_id  : '0;

  assign m1_rvalid = m1_sel & s_rvalid;
  assign m1_rdata  = m1_sel ? s_rdata : '0;
  assign m1_rresp  = m1_sel ? s_rresp : '0;
  assign m1_rlast  = m1_sel & s_rlast;
  assign m1_rid    = m1_sel ? ret_id  : '0;

  assign s_rready = (m0_sel & m0_rready) | (m1_sel & m1_rready);

  // Burst FSM with registered slave AR channel and sticky RID error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      gnt_idx   <= M_INST;
      s_arid    <= '0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
      s_arlock  <= '0;
      s_arcache <= '0;
      s_arprot  <= '0;
      s_arvalid <= 1'b0;
      rid_err   <= 1'b0;
    end else begin
      // Stray beats outside DATA, or beats tagged for the wrong master
      if (s_rvalid && ((state != ST_DATA) || (s_rid[0] != gnt_idx))) begin
        rid_err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (take) begin
            gnt_idx   <= grant[1];
            s_arid    <= {sel_id[ID_W-2:0], grant[1]};
            s_araddr  <= sel_addr;
            s_arlen   <= sel_len;
            s_arsize  <= sel_size;
            s_arburst <= sel_burst;
            s_arlock  <= sel_lock;
            s_arcache <= sel_cache;
            s_arprot  <= sel_prot;
            s_arvalid <= 1'b1;
            state     <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (s_arready) begin
            s_arid    <= '0;
            s_araddr  <= '0;
            s_arlen   <= '0;
            s_arsize  <= '0;
            s_arburst <= '0;
            s_arlock  <= '0;
            s_arcache <= '0;
            s_arprot  <= '0;
            s_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ID_W, default 4: AXI ID width on the master and slave ports.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: read data width.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 m0_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  in  ID_W/ADDR_W/8/3/2/2/4/3/1  instruction-side AR request.
REQ-007 m0_arready  out  1  instruction-side AR accept.
REQ-008 m0_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  instruction-side R response; m0_rready  in  1.
REQ-009 m1_* (same set as REQ-006..008)  in/out  same widths  data-side read port.
REQ-010 s_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  same widths  merged AR to AXI slave; s_arready  in  1.
REQ-011 s_rid/rdata/rresp/rlast/rvalid  in  same widths; s_rready  out  1  merged R from AXI slave.
REQ-012 rid_err  out  1  sticky flag: returned RID did not match the granted master.

Function
REQ-013 The block SHALL run an FSM with states IDLE, ADDR and DATA, and SHALL allow at most one outstanding burst in total.
REQ-014 In IDLE, with any mX_arvalid high, the block SHALL grant one master, pulse that master's mX_arready for exactly that cycle, and register its AR fields.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests, grant the master not granted last. The pointer SHALL favour M1 after reset.
REQ-016 The registered s_arid SHALL equal {mX_arid[ID_W-2:0], X}, so bit 0 carries the master index. All other AR fields SHALL pass unchanged.
REQ-017 s_arvalid SHALL rise in the cycle after the grant (state ADDR) and SHALL hold with stable fields until s_arready is sampled high. The FSM then enters DATA and clears s_arvalid and all s_ar* fields to 0.
REQ-018 In DATA, s_rdata/rresp/rlast/rvalid SHALL route combinationally to the granted master only. The other master's rvalid SHALL be 0. s_rready SHALL equal the granted mX_rready. mX_rid SHALL equal {1'b0, s_rid[ID_W-1:1]}.
REQ-019 A beat with s_rvalid & s_rready & s_rlast SHALL return the FSM to IDLE on the next edge. Non-last beats SHALL keep the FSM in DATA.
REQ-020 In DATA, if s_rvalid is high and s_rid[0] differs from the grant, rid_err SHALL set. It SHALL stay set until reset, and routing SHALL still follow the grant.
REQ-021 Both mX_arready SHALL be 0 outside IDLE. A request arriving in ADDR or DATA SHALL wait, with no request lost.
REQ-022 Minimum turnaround SHALL be: grant (cycle 0), s_arvalid (cycle 1), earliest next grant the cycle after the last beat.
REQ-023 s_rvalid seen in IDLE or ADDR SHALL be ignored (s_rready=0) and SHALL set rid_err.

Reset
REQ-024 While resetn=0 at a clock edge, the FSM SHALL go to IDLE and the pointer to favour M1. All s_ar* outputs, s_arvalid, mX_arready, mX_rvalid, s_rready and rid_err SHALL be 0.
REQ-025 Reset asserted mid-ADDR or mid-DATA SHALL abandon the burst with no resumption. Any later stray R beats SHALL be handled per REQ-023.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the master index constants (M_INST=0, M_DATA=1) and the AXI burst/size constants.
REQ-027 The round-robin choice SHALL live in one sub-module, rr_arbiter2: req[1:0] and advance in, grant one-hot out, with its own pointer register.

Verification
REQ-028 Reset held 3 cycles, then released with no requests -> all outputs 0, FSM in IDLE.
REQ-029 m0 and m1 request together from reset (m0 araddr 0x1C000000, m1 araddr 0x80001000) -> m1 granted first with s_arid=0x1 and s_araddr=0x80001000; m0 granted after m1's rlast.
REQ-030 m0 single beat, s_arready delayed 3 cycles -> s_arvalid held with s_araddr stable for 4 cycles; rdata 0x24020001 reaches m0 only, m0_rid=0, FSM returns to IDLE.
REQ-031 m1 4-beat burst (arlen=3), m1_rready low on beat 2 -> s_rready low that cycle, beats delivered in order, IDLE only after the 4th (rlast) beat.
REQ-032 Granted m0 but slave returns s_rid=0x1 -> rid_err rises and stays high; data still goes to m0.
REQ-033 resetn dropped during DATA of a 4-beat burst -> next cycle FSM in IDLE with all outputs 0; fresh m0 request afterwards completes normally.
